// File: rtl/zl_sync_invert_derandomizer_pkg.sv
// rtl/zl_sync_invert_derandomizer_pkg.sv - shared DVB-S sync/PRBS constants, FSM encoding and PRBS step helper
package zl_sync_invert_derandomizer_pkg;

    localparam int PACKET_LEN    = 188;
    localparam int LOCK_THRESH   = 8;
    localparam int UNLOCK_THRESH = 3;

    localparam logic [7:0]  DVB_S_SYNC      = 8'h47;
    localparam logic [7:0]  DVB_S_SYNC_INV  = 8'hB8;
    localparam logic [14:0] DVB_S_PRBS_INIT = 15'h4A80;
    localparam int          DVB_S_SF_LEN    = 8;

    typedef enum logic [1:0] {
        ST_SEARCH = 2'd0,
        ST_VERIFY = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    typedef struct packed {
        logic [14:0] state;
        logic [7:0]  bits;
    } prbs_step_t;

    // Eight steps of 1+x^14+x^15. Bit 14 is stage 1, bit 0 is stage 15;
    // the first generated bit lands in the byte MSB.
    function automatic prbs_step_t prbs_step8(input logic [14:0] s);
        prbs_step_t  r;
        logic [14:0] t;
        logic        fb;
        t      = s;
        r.bits = '0;
        for (int i = 0; i < 8; i++) begin
            fb     = t[1] ^ t[0];
            t      = {fb, t[14:1]};
            r.bits = {r.bits[6:0], fb};
        end
        r.state = t;
        return r;
    endfunction

endpackage

// File: rtl/zl_dvb_s_prbs_byte.sv
// rtl/zl_dvb_s_prbs_byte.sv - 15-bit DVB-S PRBS with load/advance and byte-wide output
module zl_dvb_s_prbs_byte
    import zl_sync_invert_derandomizer_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic       advance,
    output logic [7:0] prbs_byte
);

    logic [14:0] lfsr;
    prbs_step_t  step;

    assign step      = prbs_step8(lfsr);
    assign prbs_byte = step.bits;

    // Load wins over advance so a superframe restart always begins from the init word
    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr <= DVB_S_PRBS_INIT;
        end else if (load) begin
            lfsr <= DVB_S_PRBS_INIT;
        end else if (advance) begin
            lfsr <= step.state;
        end
    end

endmodule

// File: rtl/zl_sync_invert_derandomizer.sv
// rtl/zl_sync_invert_derandomizer.sv - DVB-S RX sync acquisition, 0xB8 re-inversion and PRBS removal (option: ZL_DVB_S_DERAND_STATS_EN)
module zl_sync_invert_derandomizer
    import zl_sync_invert_derandomizer_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  data_in,
    input  logic        data_in_req,
    output logic        data_in_ack,
    output logic [7:0]  data_out,
    output logic        data_out_sop,
    output logic        data_out_req,
    input  logic        data_out_ack,
    output logic        locked
`ifdef ZL_DVB_S_DERAND_STATS_EN
    ,
    output logic [15:0] sync_loss_cnt,
    output logic [31:0] pkt_cnt
`endif
);

    state_t     state, state_n;
    logic [7:0] pos, pos_n;
    logic [2:0] sf, sf_n;
    logic [3:0] good, good_n;
    logic [1:0] miss, miss_n;
    logic       prbs_load, prbs_adv;
    logic [7:0] prbs_byte;
    logic       emit, emit_sop;
    logic [7:0] emit_byte;
    logic       restart;

    logic       xfer, at_sync, sync_ok, is_cand, good_hit, miss_hit, pkt_end, lost;
    logic [7:0] exp_sync;

    assign data_in_ack = !data_out_req || data_out_ack;
    assign xfer        = data_in_req && data_in_ack;
    assign at_sync     = (pos == 8'd0);
    assign exp_sync    = (sf == 3'd0) ? DVB_S_SYNC_INV : DVB_S_SYNC;
    assign sync_ok     = (data_in == exp_sync);
    assign is_cand     = (data_in == DVB_S_SYNC_INV);
    assign good_hit    = (good == 4'(LOCK_THRESH - 1));
    assign miss_hit    = (miss == 2'(UNLOCK_THRESH - 1));
    assign pkt_end     = (pos == 8'(PACKET_LEN - 1));
    assign lost        = (state == ST_LOCKED) && at_sync && !sync_ok && miss_hit;

    zl_dvb_s_prbs_byte u_prbs (
        .clk       (clk),
        .rst       (rst),
        .load      (prbs_load),
        .advance   (prbs_adv),
        .prbs_byte (prbs_byte)
    );

    // FSM state register, only moves on an accepted byte
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_SEARCH;
        end else if (xfer) begin
            state <= state_n;
        end
    end

    // Next-state: a byte that breaks sync may itself be the next 0xB8 candidate
    always_comb begin
        state_n = state;
        case (state)
            ST_SEARCH: begin
                if (is_cand) state_n = ST_VERIFY;
            end
            ST_VERIFY: begin
                if (at_sync) begin
                    if (sync_ok) begin
                        if (good_hit) state_n = ST_LOCKED;
                    end else begin
                        state_n = is_cand ? ST_VERIFY : ST_SEARCH;
                    end
                end
            end
            ST_LOCKED: begin
                if (lost) state_n = is_cand ? ST_VERIFY : ST_SEARCH;
            end
            default: state_n = ST_SEARCH;
        endcase
    end

    // Per-byte controls: position tracking, PRBS stepping, good/miss counting and emission
    always_comb begin
        pos_n     = pos;
        sf_n      = sf;
        good_n    = good;
        miss_n    = miss;
        prbs_load = 1'b0;
        prbs_adv  = 1'b0;
        emit      = 1'b0;
        emit_sop  = 1'b0;
        emit_byte = data_in ^ prbs_byte;
        restart   = (state_n == ST_VERIFY) && ((state == ST_SEARCH) || (at_sync && !sync_ok));
        if (xfer) begin
            if (restart) begin
                pos_n     = 8'd1;
                sf_n      = 3'd0;
                good_n    = 4'd0;
                miss_n    = 2'd0;
                prbs_load = 1'b1;
            end else if (state_n == ST_SEARCH) begin
                pos_n  = 8'd0;
                sf_n   = 3'd0;
                good_n = 4'd0;
                miss_n = 2'd0;
            end else begin
                pos_n = pkt_end ? 8'd0 : pos + 8'd1;
                sf_n  = pkt_end ? sf + 3'd1 : sf;
                // The PRBS restarts at every 0xB8 slot and free-runs through 0x47 slots
                if (at_sync && (sf == 3'd0)) prbs_load = 1'b1;
                else                         prbs_adv  = 1'b1;
                if (at_sync) begin
                    if (state == ST_VERIFY) begin
                        good_n = (good == 4'hF) ? good : good + 4'd1;
                        miss_n = 2'd0;
                    end else if (sync_ok) begin
                        miss_n = 2'd0;
                    end else begin
                        miss_n = (miss == 2'd3) ? miss : miss + 2'd1;
                    end
                end
                if (state_n == ST_LOCKED) begin
                    emit     = 1'b1;
                    emit_sop = at_sync;
                    if (at_sync) emit_byte = DVB_S_SYNC;
                end
            end
        end
    end

    // Position, superframe slot and sync-quality counters
    always_ff @(posedge clk) begin
        if (rst) begin
            pos  <= 8'd0;
            sf   <= 3'd0;
            good <= 4'd0;
            miss <= 2'd0;
        end else begin
            pos  <= pos_n;
            sf   <= sf_n;
            good <= good_n;
            miss <= miss_n;
        end
    end

    // Single output register; holds while downstream stalls
    always_ff @(posedge clk) begin
        if (rst) begin
            data_out     <= 8'd0;
            data_out_sop <= 1'b0;
            data_out_req <= 1'b0;
        end else if (emit) begin
            data_out     <= emit_byte;
            data_out_sop <= emit_sop;
            data_out_req <= 1'b1;
        end else if (data_out_ack) begin
            data_out_req <= 1'b0;
        end
    end

    // Lock flag follows the state entered by the current transfer
    always_ff @(posedge clk) begin
        if (rst) begin
            locked <= 1'b0;
        end else if (xfer) begin
            locked <= (state_n == ST_LOCKED);
        end
    end

`ifdef ZL_DVB_S_DERAND_STATS_EN
    // Saturating lock-loss and delivered-packet counters
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_loss_cnt <= 16'd0;
            pkt_cnt       <= 32'd0;
        end else begin
            if (xfer && (state == ST_LOCKED) && (state_n != ST_LOCKED) && (sync_loss_cnt != 16'hFFFF))
                sync_loss_cnt <= sync_loss_cnt + 16'd1;
            if (emit && emit_sop && (pkt_cnt != 32'hFFFF_FFFF))
                pkt_cnt <= pkt_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_zl_sync_invert_derandomizer.sv
// tb/tb_zl_sync_invert_derandomizer.sv - table-driven bench for the DVB-S sync-invert derandomizer
module tb_zl_sync_invert_derandomizer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] data_in = 8'd0;
    logic       data_in_req = 1'b0;
    logic       data_in_ack;
    logic [7:0] data_out;
    logic       data_out_sop;
    logic       data_out_req;
    logic       data_out_ack = 1'b1;
    logic       locked;
`ifdef ZL_DVB_S_DERAND_STATS_EN
    logic [15:0] sync_loss_cnt;
    logic [31:0] pkt_cnt;
`endif

    int checks   = 0;
    int failures = 0;
    bit stall_en = 0;
    bit ack_hold = 0;

    logic [7:0] tx_q[$];
    logic [8:0] exp_q[$];
    logic [8:0] out_q[$];

    typedef struct {
        int junk;
        bit false_sync;
        int n_pkts;
        bit zero_pl;
        bit stall;
        bit no_false;
        int c_lo;
        int c_hi;
        int lock_pkt;
        int drop_lo;
        int drop_hi;
        int exp_count;
        bit exp_locked;
        int exp_pkts;
        int exp_loss;
    } vec_t;

    zl_sync_invert_derandomizer dut (
        .clk          (clk),
        .rst          (rst),
        .data_in      (data_in),
        .data_in_req  (data_in_req),
        .data_in_ack  (data_in_ack),
        .data_out     (data_out),
        .data_out_sop (data_out_sop),
        .data_out_req (data_out_req),
        .data_out_ack (data_out_ack),
        .locked       (locked)
`ifdef ZL_DVB_S_DERAND_STATS_EN
        ,
        .sync_loss_cnt(sync_loss_cnt),
        .pkt_cnt      (pkt_cnt)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        data_out_ack = ack_hold ? 1'b0 : (stall_en ? 1'($urandom_range(0, 1)) : 1'b1);
    end

    always @(negedge clk) begin
        if (!rst && data_out_req && data_out_ack) out_q.push_back({data_out_sop, data_out});
    end

    initial begin
        #20_000_000;
        $display("FAIL watchdog: simulation time exhausted");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference scrambler, stage 1 at index 1, output = stage14 ^ stage15
    function automatic logic [7:0] prbs8(inout logic [1:15] s);
        logic [7:0] r;
        logic       fb;
        r = 8'd0;
        for (int i = 0; i < 8; i++) begin
            fb = s[14] ^ s[15];
            s  = {fb, s[1:14]};
            r  = {r[6:0], fb};
        end
        return r;
    endfunction

    task automatic build(input vec_t v);
        logic [1:15] sr;
        logic [7:0]  pb, c, p8, sy;
        int          cnt;
        bit          keep;
        cnt = 0;
        sr  = 15'b100101010000000;
        tx_q.delete();
        exp_q.delete();
        for (int k = 0; k < v.n_pkts; k++) begin
            keep = (k >= v.lock_pkt) && !(k >= v.drop_lo && k < v.drop_hi);
            if (k % 8 == 0) begin
                sr = 15'b100101010000000;
                sy = 8'hB8;
            end else begin
                sy = 8'h47;
                p8 = prbs8(sr);
            end
            if (k >= v.c_lo && k < v.c_hi) sy = 8'h00;
            tx_q.push_back(sy);
            if (keep) exp_q.push_back({1'b1, 8'h47});
            for (int j = 1; j < 188; j++) begin
                p8 = prbs8(sr);
                pb = v.zero_pl ? 8'h00 : cnt[7:0];
                cnt++;
                c = pb ^ p8;
                if (v.no_false && c == 8'hB8) begin
                    pb = pb + 8'd1;
                    c  = pb ^ p8;
                end
                tx_q.push_back(c);
                if (keep) exp_q.push_back({1'b0, pb});
            end
        end
    endtask

    task automatic put(input logic [7:0] b);
        int n;
        n           = 0;
        data_in     = b;
        data_in_req = 1'b1;
        @(negedge clk);
        while (!data_in_ack && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!data_in_ack) check("put_timeout", 0, 1);
        @(posedge clk);
        #1;
        data_in_req = 1'b0;
    endtask

    task automatic do_reset();
        rst         = 1'b1;
        data_in_req = 1'b0;
        ack_hold    = 0;
        stall_en    = 0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        out_q.delete();
    endtask

    vec_t       vecs[6];
    vec_t       vr;
    logic [7:0] held;
    int         errs, first_bad, n_cmp;

    initial begin
        vecs[0] = '{0,  0, 16, 1, 0, 0, 0,  0,  8, 0,  0,  1504, 1, 8,  0};
        vecs[1] = '{0,  0, 16, 0, 1, 0, 0,  0,  8, 0,  0,  1504, 1, 8,  0};
        vecs[2] = '{37, 0, 16, 0, 0, 0, 0,  0,  8, 0,  0,  1504, 1, 8,  0};
        vecs[3] = '{0,  0, 16, 0, 1, 0, 10, 12, 8, 0,  0,  1504, 1, 8,  0};
        vecs[4] = '{0,  0, 32, 0, 0, 1, 10, 13, 8, 12, 24, 2256, 1, 12, 1};
        vecs[5] = '{0,  1, 16, 1, 0, 0, 0,  0,  8, 0,  0,  1504, 1, 8,  0};

        do_reset();
        check("rst_out_req", data_out_req, 0);
        check("rst_out", data_out, 8'h00);
        check("rst_sop", data_out_sop, 0);
        check("rst_locked", locked, 0);
        check("rst_in_ack", data_in_ack, 1);

        for (int r = 0; r < 6; r++) begin
            do_reset();
            build(vecs[r]);
            stall_en = vecs[r].stall;
            for (int i = 0; i < vecs[r].junk; i++) put(8'h5A ^ 8'(i));
            if (vecs[r].false_sync) begin
                put(8'hB8);
                for (int i = 0; i < 188; i++) put(8'h00);
                check($sformatf("row%0d_false_locked", r), locked, 0);
                check($sformatf("row%0d_false_outputs", r), out_q.size(), 0);
            end
            foreach (tx_q[i]) put(tx_q[i]);
            stall_en = 0;
            repeat (20) @(negedge clk);
            check($sformatf("row%0d_count", r), out_q.size(), vecs[r].exp_count);
            errs      = 0;
            first_bad = -1;
            n_cmp     = (out_q.size() < exp_q.size()) ? out_q.size() : exp_q.size();
            for (int i = 0; i < n_cmp; i++) begin
                if (out_q[i] !== exp_q[i]) begin
                    if (first_bad < 0) first_bad = i;
                    errs++;
                end
            end
            if (first_bad >= 0)
                $display("row%0d first differing byte %0d: got %h expected %h",
                         r, first_bad, out_q[first_bad], exp_q[first_bad]);
            check($sformatf("row%0d_content_errors", r), errs, 0);
            check($sformatf("row%0d_first_is_sop47", r), (out_q.size() > 0) ? out_q[0] : 9'h0, 9'h147);
            check($sformatf("row%0d_locked_end", r), locked, vecs[r].exp_locked);
`ifdef ZL_DVB_S_DERAND_STATS_EN
            check($sformatf("row%0d_pkt_cnt", r), pkt_cnt, vecs[r].exp_pkts);
            check($sformatf("row%0d_sync_loss", r), sync_loss_cnt, vecs[r].exp_loss);
`endif
        end

        // Stall with a byte held in the output register, then reset mid-packet
        vr = '{0, 0, 10, 1, 0, 0, 0, 0, 8, 0, 0, 0, 1, 0, 0};
        do_reset();
        build(vr);
        for (int i = 0; i < 9 * 188 + 51; i++) put(tx_q[i]);
        ack_hold     = 1;
        data_out_ack = 1'b0;
        @(negedge clk);
        held = data_out;
        check("stall_req", data_out_req, 1);
        check("stall_locked", locked, 1);
        repeat (3) @(negedge clk);
        check("stall_hold_data", data_out, held);
        check("stall_data_val", data_out, 8'h00);
        check("stall_sop", data_out_sop, 0);
        check("stall_in_ack", data_in_ack, 0);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_out_req", data_out_req, 0);
        check("midrst_locked", locked, 0);
        check("midrst_out", data_out, 8'h00);
`ifdef ZL_DVB_S_DERAND_STATS_EN
        check("midrst_pkt_cnt", pkt_cnt, 0);
        check("midrst_sync_loss", sync_loss_cnt, 0);
`endif
        ack_hold = 0;
        rst      = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
